// File: rtl/mux_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared types and helpers for the round-robin mux arbiter.
//   state_t      : arbiter FSM states (IDLE, GRANT)
//   MUX_S_DEF    : default select width, MUX_R_DEF = 2**MUX_S_DEF requesters
//   MUX_S_MAX    : largest select width the onehot() helper supports
//   onehot(idx)  : returns a MUX_R_MAX-bit one-hot vector; callers truncate to R
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MUX_S_DEF = 2;
    localparam int MUX_R_DEF = 2 ** MUX_S_DEF;

    // The helper cannot see a module parameter, so it works at the widest
    // supported size and the caller keeps the low R bits.
    localparam int MUX_S_MAX = 6;
    localparam int MUX_R_MAX = 2 ** MUX_S_MAX;

    function automatic logic [MUX_R_MAX-1:0] onehot(input logic [MUX_S_MAX-1:0] idx);
        return MUX_R_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter_if
// Requester-side bundle of the round-robin mux arbiter.
//   req     : R-bit request vector (requesters -> arbiter)
//   done    : owner releases the bus (requesters -> arbiter)
//   grant   : one-hot grant, zero when idle (arbiter -> requesters)
//   select  : binary owner index (arbiter -> mux)
//   valid   : grant/select designate an owner
//   timeout : one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mux_rr_arbiter_if #(
    parameter int S = 2
);
    localparam int R = 2 ** S;

    logic [R-1:0] req;
    logic         done;
    logic [R-1:0] grant;
    logic [S-1:0] select;
    logic         valid;
    logic         timeout;

    modport master (
        output req, done,
        input  grant, select, valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, select, valid, timeout
    );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection.
//   i_req : R-bit request vector
//   i_ptr : index with highest priority this round
//   o_any : at least one request present
//   o_idx : first requester at or above i_ptr, wrapping R-1 -> 0
// Rotates req right by ptr, priority-encodes the lowest set bit, then adds
// ptr back; the S-bit add gives the modulo-R wrap for free.
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int S = 2
) (
    input  logic [2**S-1:0] i_req,
    input  logic [S-1:0]    i_ptr,
    output logic            o_any,
    output logic [S-1:0]    o_idx
);
    localparam int R = 2 ** S;

    logic [R-1:0] w_rot;
    logic [S-1:0] w_enc;

    // w_rot[i] = i_req[(i + ptr) mod R]; the index sum is S bits wide so it wraps.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < R; i++) begin
            w_rot[i] = i_req[S'(i) + i_ptr];
        end
    end

    // Lowest set bit wins: scan downward so the last hit is the smallest index.
    always_comb begin
        w_enc = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = S'(i);
            end
        end
    end

    assign o_any = |i_req;
    assign o_idx = w_enc + i_ptr;

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter driving the select input of a 2**S-way bus mux.
// A grant is held until the owner raises done or drops its request; every
// release is followed by one IDLE cycle before the next arbitration.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mux_rr_arbiter_if.slave (req, done in; grant, select, valid, timeout out)
// Parameters: S (select width), MAX_HOLD (grant cycle limit, timeout build only).
// Build option: define ARB_TIMEOUT_EN to force a release after MAX_HOLD grant
// cycles and pulse timeout; otherwise timeout is tied low and grants are held
// indefinitely.
// -----------------------------------------------------------------------------
module mux_rr_arbiter
    import mux_pkg::*;
#(
    parameter int S        = MUX_S_DEF,
    parameter int MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst,
    mux_rr_arbiter_if.slave    bus
);
    localparam int R = 2 ** S;

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("mux_rr_arbiter: MAX_HOLD must be >= 1");
    end
    if (S > MUX_S_MAX) begin : g_bad_s
        $error("mux_rr_arbiter: S exceeds MUX_S_MAX");
    end

    state_t       r_state, w_state_nxt;
    logic [R-1:0] r_grant, w_grant_nxt;
    logic [S-1:0] r_select, w_select_nxt;
    logic         r_valid, w_valid_nxt;
    logic [S-1:0] r_ptr, w_ptr_nxt;

    logic         w_any;
    logic [S-1:0] w_idx;
    logic         w_release;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic          r_timeout, w_timeout_nxt;
`endif

    rr_pick #(.S(S)) u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    assign w_release = bus.done | ~bus.req[r_select];

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_select_nxt = r_select;
        w_valid_nxt  = r_valid;
        w_ptr_nxt    = r_ptr;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt  = GRANT;
                    w_grant_nxt  = R'(onehot(MUX_S_MAX'(w_idx)));
                    w_select_nxt = w_idx;
                    w_valid_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt   = '0;
`endif
                end
            end
            GRANT: begin
                // A normal release outranks the timeout in the same cycle.
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = r_select + 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                // Counter holds completed grant cycles; this cycle is the
                // MAX_HOLD-th, so the grant has been visible MAX_HOLD cycles.
                else if (r_hold == HW'(MAX_HOLD - 1)) begin
                    w_state_nxt   = IDLE;
                    w_grant_nxt   = '0;
                    w_valid_nxt   = 1'b0;
                    w_ptr_nxt     = r_select + 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_select <= '0;
            r_valid  <= 1'b0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_select <= w_select_nxt;
            r_valid  <= w_valid_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant  = r_grant;
    assign bus.select = r_select;
    assign bus.valid  = r_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Directed vectors for mux_rr_arbiter (S=2, R=4). Each step drives req/done,
// queues the outputs expected after the next rising edge, and a monitor on the
// falling edge pops and compares. The MAX_HOLD=3 timeout vectors apply when
// ARB_TIMEOUT_EN is defined; otherwise a long-hold sequence checks that the
// grant is never dropped.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;
    localparam int S        = 2;
    localparam int R        = 4;
    localparam int MAX_HOLD = 3;

    typedef struct packed {
        logic [R-1:0] g;
        logic [S-1:0] s;
        logic         v;
        logic         t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.S(S)) bus ();

    mux_rr_arbiter #(.S(S), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_vec++;
            if ({bus.grant, bus.select, bus.valid, bus.timeout} !== mon_e) begin
                n_bad++;
                $display("FAIL vec%0d: got g=%b s=%0d v=%b t=%b, want g=%b s=%0d v=%b t=%b",
                         n_vec, bus.grant, bus.select, bus.valid, bus.timeout,
                         mon_e.g, mon_e.s, mon_e.v, mon_e.t);
            end
        end
    end

    // Drive inputs just after a falling edge, expect result after the next rise.
    task automatic step(input logic [R-1:0] rq, input logic dn,
                        input logic [R-1:0] g, input logic [S-1:0] s,
                        input logic v, input logic t);
        exp_t e;
        bus.req  = rq;
        bus.done = dn;
        e = '{g: g, s: s, v: v, t: t};
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [R-1:0] g,
                             input logic [S-1:0] s, input logic v, input logic t);
        n_vec++;
        if ({bus.grant, bus.select, bus.valid, bus.timeout} !== {g, s, v, t}) begin
            n_bad++;
            $display("FAIL %s: got g=%b s=%0d v=%b t=%b, want g=%b s=%0d v=%b t=%b",
                     name, bus.grant, bus.select, bus.valid, bus.timeout, g, s, v, t);
        end
    endtask

    initial begin
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        #3;
        check_now("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Fairness: all requesting, done pulsed in each grant -> 0,1,2,3,0.
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);   // ptr=1

        // Single requester 2, released by done -> ptr=3; idle keeps select.
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);

        // ptr=3 with req 0101: wraps to 0 rather than picking 2.
        step(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);   // ptr=1

        // Owner 1 drops its request while 0 and 3 request: release, then 3.
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);   // ptr=2
        step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        // No preemption by other requesters.
        step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);   // ptr=0
        // done in IDLE has no effect.
        step(4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);

        // Asynchronous reset between edges while granted.
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1 check_now("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);   // ptr=1

`ifdef ARB_TIMEOUT_EN
        // Held for MAX_HOLD=3 cycles, forced release with timeout pulse.
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1);   // ptr=3
        // Re-grant after the idle cycle; done on the limit cycle wins, no pulse.
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);
`else
        // Without the timeout the grant is held indefinitely.
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        step(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
